// File: rtl/ex_stage.sv
// ex_stage: execute stage of the five-stage pipeline, feeding the memory stage.
//
// Takes a decoded instruction with its operand values, computes the ALU result
// or effective address, and registers the EX/MEM outputs. MUL/MULI use an
// iterative 4-bits-per-cycle multiplier that occupies 8 cycles and holds off
// decode through busy. HALT sets a halt flag that stays set until reset.
//
// Ports:
//   clk, reset     clock (rising edge), asynchronous active-low reset
//   in_valid       decode presents an instruction this cycle
//   opcode         6-bit opcode
//   rs_val/rt_val  operand values; rt_val is the store data for STW
//   imm            16-bit immediate, sign-extended here
//   dest_addr      destination register chosen by decode
//   flush          drops the presented instruction and aborts a multiply
//   busy           combinational, multiply in progress
//   mem_write, mem_read, mem_to_reg, addr_out, addr_reg_out, write_data
//                  registered EX/MEM outputs (all zero for a bubble)
//   halt           registered, sticky halt flag
//
// Fields the memory stage does not use for an instruction are driven to zero:
// addr_out is only non-zero for LDW/STW, write_data is zero for LDW.
// addr_reg_out carries dest_addr for every non-bubble instruction.
module ex_stage #(
  parameter int D_SIZE        = 32,
  parameter int ADDR_LINE_MEM = 14,
  parameter int ADDR_LINE_REG = 5
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     in_valid,
  input  logic [5:0]               opcode,
  input  logic [D_SIZE-1:0]        rs_val,
  input  logic [D_SIZE-1:0]        rt_val,
  input  logic [15:0]              imm,
  input  logic [ADDR_LINE_REG-1:0] dest_addr,
  input  logic                     flush,
  output logic                     busy,
  output logic                     mem_write,
  output logic                     mem_read,
  output logic                     mem_to_reg,
  output logic [ADDR_LINE_MEM-1:0] addr_out,
  output logic [ADDR_LINE_REG-1:0] addr_reg_out,
  output logic [D_SIZE-1:0]        write_data,
  output logic                     halt
);

  localparam logic [5:0] OP_ADD  = 6'h00;
  localparam logic [5:0] OP_ADDI = 6'h01;
  localparam logic [5:0] OP_SUB  = 6'h02;
  localparam logic [5:0] OP_SUBI = 6'h03;
  localparam logic [5:0] OP_MUL  = 6'h04;
  localparam logic [5:0] OP_MULI = 6'h05;
  localparam logic [5:0] OP_OR   = 6'h06;
  localparam logic [5:0] OP_ORI  = 6'h07;
  localparam logic [5:0] OP_AND  = 6'h08;
  localparam logic [5:0] OP_ANDI = 6'h09;
  localparam logic [5:0] OP_XOR  = 6'h0A;
  localparam logic [5:0] OP_XORI = 6'h0B;
  localparam logic [5:0] OP_LDW  = 6'h0C;
  localparam logic [5:0] OP_STW  = 6'h0D;
  localparam logic [5:0] OP_HALT = 6'h11;

  typedef enum logic {S_IDLE = 1'b0, S_MULT = 1'b1} state_e;

  state_e                   state_q, state_d;
  logic [2:0]               cnt_q, cnt_d;
  logic [D_SIZE-1:0]        mcand_q, mcand_d;
  logic [D_SIZE-1:0]        mplier_q, mplier_d;
  logic [D_SIZE-1:0]        acc_q, acc_d;
  logic [ADDR_LINE_REG-1:0] mdest_q, mdest_d;
  logic                     halt_q, halt_d;

  logic                     mem_write_q, mem_write_d;
  logic                     mem_read_q, mem_read_d;
  logic                     mem_to_reg_q, mem_to_reg_d;
  logic [ADDR_LINE_MEM-1:0] addr_q, addr_d;
  logic [ADDR_LINE_REG-1:0] addr_reg_q, addr_reg_d;
  logic [D_SIZE-1:0]        write_data_q, write_data_d;

  logic [D_SIZE-1:0]        imm_ext;
  logic [D_SIZE-1:0]        op_b;
  logic [D_SIZE-1:0]        partial;
  logic                     accept;

  // Odd opcodes in the ALU range are the immediate forms.
  assign imm_ext = {{(D_SIZE-16){imm[15]}}, imm};
  assign op_b    = opcode[0] ? imm_ext : rt_val;
  assign busy    = (state_q == S_MULT);
  assign accept  = in_valid && !busy && !flush && !halt_q;
  // The multiplicand is pre-shifted every cycle, so this equals
  // original_multiplicand * nibble << (4*cnt).
  assign partial = mcand_q * D_SIZE'(mplier_q[3:0]);

  // Multiply FSM and halt flag registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= S_IDLE;
      cnt_q    <= 3'd0;
      mcand_q  <= {D_SIZE{1'b0}};
      mplier_q <= {D_SIZE{1'b0}};
      acc_q    <= {D_SIZE{1'b0}};
      mdest_q  <= {ADDR_LINE_REG{1'b0}};
      halt_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
      acc_q    <= acc_d;
      mdest_q  <= mdest_d;
      halt_q   <= halt_d;
    end
  end

  // Next-state logic: multiply sequencing, operand loading and halt capture.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    mcand_d  = mcand_q;
    mplier_d = mplier_q;
    acc_d    = acc_q;
    mdest_d  = mdest_q;
    halt_d   = halt_q;
    if (state_q == S_MULT) begin
      if (flush) begin
        state_d = S_IDLE;
        cnt_d   = 3'd0;
      end else begin
        acc_d    = acc_q + partial;
        mcand_d  = {mcand_q[D_SIZE-5:0], 4'h0};
        mplier_d = {4'h0, mplier_q[D_SIZE-1:4]};
        cnt_d    = cnt_q + 3'd1;
        if (cnt_q == 3'd7) begin
          state_d = S_IDLE;
        end else begin
          state_d = S_MULT;
        end
      end
    end else if (accept) begin
      case (opcode)
        OP_MUL, OP_MULI: begin
          state_d  = S_MULT;
          cnt_d    = 3'd0;
          acc_d    = {D_SIZE{1'b0}};
          mcand_d  = rs_val;
          mplier_d = op_b;
          mdest_d  = dest_addr;
        end
        OP_HALT: halt_d = 1'b1;
        default: halt_d = halt_q;
      endcase
    end else begin
      state_d = S_IDLE;
    end
  end

  // Output decode: the value the EX/MEM register takes at the next edge.
  always_comb begin
    mem_write_d  = 1'b0;
    mem_read_d   = 1'b0;
    mem_to_reg_d = 1'b0;
    addr_d       = {ADDR_LINE_MEM{1'b0}};
    addr_reg_d   = {ADDR_LINE_REG{1'b0}};
    write_data_d = {D_SIZE{1'b0}};
    if (state_q == S_MULT) begin
      // Last partial product folds straight into the registered result.
      if (!flush && (cnt_q == 3'd7)) begin
        mem_to_reg_d = 1'b1;
        addr_reg_d   = mdest_q;
        write_data_d = acc_q + partial;
      end else begin
        mem_to_reg_d = 1'b0;
      end
    end else if (accept) begin
      case (opcode)
        OP_ADD, OP_ADDI: begin
          mem_to_reg_d = 1'b1;
          addr_reg_d   = dest_addr;
          write_data_d = rs_val + op_b;
        end
        OP_SUB, OP_SUBI: begin
          mem_to_reg_d = 1'b1;
          addr_reg_d   = dest_addr;
          write_data_d = rs_val - op_b;
        end
        OP_OR, OP_ORI: begin
          mem_to_reg_d = 1'b1;
          addr_reg_d   = dest_addr;
          write_data_d = rs_val | op_b;
        end
        OP_AND, OP_ANDI: begin
          mem_to_reg_d = 1'b1;
          addr_reg_d   = dest_addr;
          write_data_d = rs_val & op_b;
        end
        OP_XOR, OP_XORI: begin
          mem_to_reg_d = 1'b1;
          addr_reg_d   = dest_addr;
          write_data_d = rs_val ^ op_b;
        end
        OP_LDW: begin
          mem_read_d   = 1'b1;
          mem_to_reg_d = 1'b1;
          addr_reg_d   = dest_addr;
          addr_d       = ADDR_LINE_MEM'((rs_val + imm_ext) >> 2);
        end
        OP_STW: begin
          mem_write_d  = 1'b1;
          addr_reg_d   = dest_addr;
          addr_d       = ADDR_LINE_MEM'((rs_val + imm_ext) >> 2);
          write_data_d = rt_val;
        end
        default: mem_to_reg_d = 1'b0;
      endcase
    end else begin
      mem_to_reg_d = 1'b0;
    end
  end

  // EX/MEM pipeline output registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      mem_write_q  <= 1'b0;
      mem_read_q   <= 1'b0;
      mem_to_reg_q <= 1'b0;
      addr_q       <= {ADDR_LINE_MEM{1'b0}};
      addr_reg_q   <= {ADDR_LINE_REG{1'b0}};
      write_data_q <= {D_SIZE{1'b0}};
    end else begin
      mem_write_q  <= mem_write_d;
      mem_read_q   <= mem_read_d;
      mem_to_reg_q <= mem_to_reg_d;
      addr_q       <= addr_d;
      addr_reg_q   <= addr_reg_d;
      write_data_q <= write_data_d;
    end
  end

  assign mem_write    = mem_write_q;
  assign mem_read     = mem_read_q;
  assign mem_to_reg   = mem_to_reg_q;
  assign addr_out     = addr_q;
  assign addr_reg_out = addr_reg_q;
  assign write_data   = write_data_q;
  assign halt         = halt_q;

endmodule

// File: tb/tb_ex_stage.sv
// Testbench for ex_stage: a behavioural model predicts every output each cycle
// and is compared on the falling edge; directed literal checks pin the model.
module tb_ex_stage;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        in_valid = 1'b0;
  logic [5:0]  opcode = 6'h00;
  logic [31:0] rs_val = 32'h0;
  logic [31:0] rt_val = 32'h0;
  logic [15:0] imm = 16'h0;
  logic [4:0]  dest_addr = 5'h0;
  logic        flush = 1'b0;
  logic        busy, mem_write, mem_read, mem_to_reg, halt;
  logic [13:0] addr_out;
  logic [4:0]  addr_reg_out;
  logic [31:0] write_data;

  int total = 0;
  int bad = 0;

  ex_stage dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .opcode(opcode),
    .rs_val(rs_val), .rt_val(rt_val), .imm(imm), .dest_addr(dest_addr),
    .flush(flush), .busy(busy), .mem_write(mem_write), .mem_read(mem_read),
    .mem_to_reg(mem_to_reg), .addr_out(addr_out), .addr_reg_out(addr_reg_out),
    .write_data(write_data), .halt(halt)
  );

  always #5 clk = ~clk;

  // Reference model state
  logic        m_halt = 1'b0;
  int          m_busy_left = 0;
  logic [31:0] m_res = 32'h0;
  logic [4:0]  m_dest = 5'h0;
  logic        e_mw = 1'b0, e_mr = 1'b0, e_m2r = 1'b0;
  logic [13:0] e_addr = 14'h0;
  logic [4:0]  e_ar = 5'h0;
  logic [31:0] e_wd = 32'h0;

  wire [31:0] t_se   = {{16{imm[15]}}, imm};
  wire [31:0] t_b    = opcode[0] ? t_se : rt_val;
  wire [31:0] t_ea   = rs_val + t_se;
  wire [31:0] t_prod = rs_val * t_b;

  function automatic logic [31:0] f_alu(input logic [5:0] op, input logic [31:0] a, input logic [31:0] b);
    case (op)
      6'h00, 6'h01: return a + b;
      6'h02, 6'h03: return a - b;
      6'h06, 6'h07: return a | b;
      6'h08, 6'h09: return a & b;
      6'h0A, 6'h0B: return a ^ b;
      default:      return 32'h0;
    endcase
  endfunction

  function automatic bit is_alu(input logic [5:0] op);
    return (op <= 6'h0B) && (op != 6'h04) && (op != 6'h05);
  endfunction

  // Model: predicts the outputs registered at each rising edge.
  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      m_halt <= 1'b0; m_busy_left <= 0; m_res <= 32'h0; m_dest <= 5'h0;
      e_mw <= 1'b0; e_mr <= 1'b0; e_m2r <= 1'b0; e_addr <= 14'h0; e_ar <= 5'h0; e_wd <= 32'h0;
    end else begin
      e_mw <= 1'b0; e_mr <= 1'b0; e_m2r <= 1'b0; e_addr <= 14'h0; e_ar <= 5'h0; e_wd <= 32'h0;
      if (m_busy_left != 0) begin
        if (flush) begin
          m_busy_left <= 0;
        end else begin
          m_busy_left <= m_busy_left - 1;
          if (m_busy_left == 1) begin
            e_m2r <= 1'b1; e_wd <= m_res; e_ar <= m_dest;
          end
        end
      end else if (in_valid && !flush && !m_halt) begin
        if (is_alu(opcode)) begin
          e_m2r <= 1'b1; e_ar <= dest_addr; e_wd <= f_alu(opcode, rs_val, t_b);
        end else if (opcode == 6'h04 || opcode == 6'h05) begin
          m_res <= t_prod; m_dest <= dest_addr; m_busy_left <= 8;
        end else if (opcode == 6'h0C) begin
          e_mr <= 1'b1; e_m2r <= 1'b1; e_ar <= dest_addr; e_addr <= t_ea[15:2];
        end else if (opcode == 6'h0D) begin
          e_mw <= 1'b1; e_ar <= dest_addr; e_addr <= t_ea[15:2]; e_wd <= rt_val;
        end else if (opcode == 6'h11) begin
          m_halt <= 1'b1;
        end
      end
    end
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%h expected=%h at %0t", nm, act, exp, $time);
    end
  endtask

  // Compare every output against the model on each falling edge.
  always @(negedge clk) begin
    chk("busy", 32'(busy), 32'(m_busy_left != 0));
    chk("mem_write", 32'(mem_write), 32'(e_mw));
    chk("mem_read", 32'(mem_read), 32'(e_mr));
    chk("mem_to_reg", 32'(mem_to_reg), 32'(e_m2r));
    chk("addr_out", 32'(addr_out), 32'(e_addr));
    chk("addr_reg_out", 32'(addr_reg_out), 32'(e_ar));
    chk("write_data", write_data, e_wd);
    chk("halt", 32'(halt), 32'(m_halt));
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [5:0] op, input logic [31:0] rs,
                       input logic [31:0] rt, input logic [15:0] im, input logic [4:0] d);
    in_valid = v; opcode = op; rs_val = rs; rt_val = rt; imm = im; dest_addr = d; flush = 1'b0;
  endtask

  initial begin
    // Reset held with random inputs
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, 6'($urandom_range(0, 17)), $urandom, $urandom, 16'($urandom), 5'($urandom));
      tick;
      chk("rst_wd", write_data, 32'h0);
      chk("rst_ctl", {29'h0, mem_write, mem_read, mem_to_reg}, 32'h0);
      chk("rst_busy", 32'(busy), 32'h0);
    end
    reset = 1'b1;

    drive(1'b1, 6'h00, 32'd5, 32'd7, 16'h0, 5'd3);
    tick;
    chk("add_wd", write_data, 32'd12);
    chk("add_m2r", 32'(mem_to_reg), 32'd1);
    chk("add_ar", 32'(addr_reg_out), 32'd3);

    drive(1'b1, 6'h03, 32'h0, 32'h0, 16'h0001, 5'd1);
    tick;
    chk("subi_wd", write_data, 32'hFFFF_FFFF);
    drive(1'b1, 6'h07, 32'h0, 32'h0, 16'h8000, 5'd1);
    tick;
    chk("ori_wd", write_data, 32'hFFFF_8000);

    drive(1'b1, 6'h0C, 32'h100, 32'h0, 16'h0008, 5'd4);
    tick;
    chk("ldw_mr", 32'(mem_read), 32'd1);
    chk("ldw_m2r", 32'(mem_to_reg), 32'd1);
    chk("ldw_addr", 32'(addr_out), 32'h42);

    drive(1'b1, 6'h0D, 32'h10, 32'hDEAD, 16'h0, 5'd0);
    tick;
    chk("stw_mw", 32'(mem_write), 32'd1);
    chk("stw_m2r", 32'(mem_to_reg), 32'd0);
    chk("stw_addr", 32'(addr_out), 32'd4);
    chk("stw_wd", write_data, 32'hDEAD);

    // MUL accepted in cycle 0, ADD held on the inputs behind it
    drive(1'b1, 6'h04, 32'hFFFF_FFFF, 32'd3, 16'h0, 5'd9);
    tick;
    drive(1'b1, 6'h00, 32'd1, 32'd2, 16'h0, 5'd7);
    for (int c = 1; c <= 8; c++) begin
      chk("mul_busy", 32'(busy), 32'd1);
      chk("mul_bubble", {write_data[31:3], write_data[2:0] | {mem_write, mem_read, mem_to_reg}}, 32'h0);
      tick;
    end
    chk("mul_wd", write_data, 32'hFFFF_FFFD);
    chk("mul_ar", 32'(addr_reg_out), 32'd9);
    chk("mul_busy_end", 32'(busy), 32'd0);
    tick;
    chk("add_after_mul", write_data, 32'd3);
    chk("add_after_mul_ar", 32'(addr_reg_out), 32'd7);

    // MULI flushed in cycle 4
    drive(1'b1, 6'h05, 32'd1000, 32'd0, 16'd1000, 5'd4);
    tick;
    in_valid = 1'b0;
    tick; tick; tick;
    flush = 1'b1;
    tick;
    chk("flush_busy", 32'(busy), 32'd0);
    chk("flush_wd", write_data, 32'h0);
    drive(1'b1, 6'h00, 32'd10, 32'd20, 16'h0, 5'd2);
    tick;
    chk("add_after_flush", write_data, 32'd30);
    in_valid = 1'b0;
    for (int c = 0; c < 10; c++) begin
      tick;
      chk("no_flushed_res", 32'(write_data == 32'd1000000), 32'd0);
    end

    // HALT then ADD
    drive(1'b1, 6'h11, 32'h0, 32'h0, 16'h0, 5'd0);
    tick;
    chk("halt_set", 32'(halt), 32'd1);
    drive(1'b1, 6'h00, 32'd1, 32'd1, 16'h0, 5'd1);
    tick;
    chk("halt_sticky", 32'(halt), 32'd1);
    chk("halt_ignore", write_data, 32'h0);
    chk("halt_m2r", 32'(mem_to_reg), 32'd0);
    reset = 1'b0;
    #1;
    chk("halt_cleared", 32'(halt), 32'd0);
    reset = 1'b1;
    in_valid = 1'b0;
    tick;

    // Randomized traffic
    for (int i = 0; i < 3000; i++) begin
      logic [5:0] op;
      int r;
      r = $urandom_range(0, 21);
      op = 6'(r);
      if (op == 6'h11 && $urandom_range(0, 7) != 0) op = 6'h04;
      if (r == 21) op = 6'h3F;
      in_valid  = ($urandom_range(0, 9) != 0);
      opcode    = op;
      flush     = ($urandom_range(0, 15) == 0);
      rs_val    = $urandom;
      rt_val    = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 20)) : $urandom;
      imm       = 16'($urandom);
      dest_addr = 5'($urandom);
      if ($urandom_range(0, 299) == 0 || (halt && $urandom_range(0, 19) == 0)) begin
        reset = 1'b0;
        #2;
        reset = 1'b1;
      end
      tick;
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
